// File: rtl/lc3_pkg.sv
// LC-3 decode shared types and opcode-to-control mapping.
// Used by the decode stage RTL and by the decode_in predictor.
package lc3_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0, OP_ADD  = 4'h1, OP_LD   = 4'h2, OP_ST   = 4'h3,
    OP_RSV4 = 4'h4, OP_AND  = 4'h5, OP_LDR  = 4'h6, OP_STR  = 4'h7,
    OP_RTI  = 4'h8, OP_NOT  = 4'h9, OP_LDI  = 4'hA, OP_STI  = 4'hB,
    OP_JMP  = 4'hC, OP_RSVD = 4'hD, OP_LEA  = 4'hE, OP_TRAP = 4'hF
  } op_t;

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  localparam logic [1:0] PC1_NONE = 2'b00;
  localparam logic [1:0] PC1_OFF9 = 2'b01;
  localparam logic [1:0] PC1_OFF6 = 2'b10;
  localparam logic [1:0] PC1_BASE = 2'b11;

  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_PCADD = 2'b01;
  localparam logic [1:0] WB_MEM   = 2'b10;

  localparam int E_OP2 = 0;
  localparam int E_PC2 = 1;
  localparam int E_PC1 = 2;
  localparam int E_ALU = 4;

  typedef struct packed {
    logic [5:0] e;
    logic [1:0] w;
    logic       mem;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input op_t op, input logic imm_bit);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD, OP_AND: begin
        c.e[E_ALU +: 2] = (op == OP_AND) ? ALU_AND : ALU_ADD;
        c.e[E_OP2]      = ~imm_bit;
      end
      OP_NOT: c.e[E_ALU +: 2] = ALU_NOT;
      OP_BR, OP_ST, OP_STI: begin
        c.e[E_PC1 +: 2] = PC1_OFF9;
        c.e[E_PC2]      = 1'b1;
        c.mem           = (op == OP_STI);
      end
      OP_LD, OP_LDI: begin
        c.e[E_PC1 +: 2] = PC1_OFF9;
        c.e[E_PC2]      = 1'b1;
        c.w             = WB_MEM;
        c.mem           = (op == OP_LDI);
      end
      OP_LEA: begin
        c.e[E_PC1 +: 2] = PC1_OFF9;
        c.e[E_PC2]      = 1'b1;
        c.w             = WB_PCADD;
      end
      OP_JMP: c.e[E_PC1 +: 2] = PC1_BASE;
      OP_LDR: begin
        c.e[E_PC1 +: 2] = PC1_OFF6;
        c.w             = WB_MEM;
      end
      OP_STR: c.e[E_PC1 +: 2] = PC1_OFF6;
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lc3_decode_ctrl.sv
// Combinational opcode-to-control mapper.
// Pure function of the opcode and the immediate-mode bit.
module lc3_decode_ctrl
  import lc3_pkg::*;
(
  input  logic [3:0] op,
  input  logic       imm_bit,
  output ctrl_t      ctrl
);

  assign ctrl = decode_ctrl(op_t'(op), imm_bit);

endmodule

// File: rtl/lc3_decode.sv
// LC-3 decode stage: registers the instruction and its control words.
// Adds a valid strobe, illegal-opcode flag and saturating capture count.
module lc3_decode
  import lc3_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int FLAG_ILLEGAL = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_decode,
  input  logic [15:0]      dout,
  input  logic [15:0]      npc_in,
  output logic [15:0]      IR,
  output logic [15:0]      npc_out,
  output logic [5:0]       E_Control,
  output logic [1:0]       W_Control,
  output logic             Mem_Control,
  output logic             valid_out,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_t  ctrl;
  logic   ill_d;
  logic   vld_q;
  state_t state;
  state_t state_n;

  lc3_decode_ctrl u_ctrl (
    .op      (dout[15:12]),
    .imm_bit (dout[5]),
    .ctrl    (ctrl)
  );

  assign ill_d = (FLAG_ILLEGAL != 0) && ctrl.illegal;

  // Instruction and control word register, loaded on each capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      IR          <= '0;
      npc_out     <= '0;
      E_Control   <= '0;
      W_Control   <= '0;
      Mem_Control <= 1'b0;
      illegal_op  <= 1'b0;
    end else if (enable_decode) begin
      IR          <= dout;
      npc_out     <= npc_in;
      E_Control   <= ctrl.e;
      W_Control   <= ctrl.w;
      Mem_Control <= ctrl.mem;
      illegal_op  <= ill_d;
    end
  end

  // State, valid strobe and saturating capture counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      vld_q       <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_n;
      vld_q <= enable_decode;
      if (enable_decode && (instr_count != {CNT_W{1'b1}}))
        instr_count <= instr_count + CNT_ONE;
    end
  end

  // Next state: leave IDLE on the first capture, return only on reset.
  always_comb begin
    state_n = state;
    if ((state == S_IDLE) && enable_decode)
      state_n = S_ACTIVE;
  end

  assign valid_out = vld_q && (state == S_ACTIVE);

endmodule

// File: tb/tb_lc3_decode.sv
// Self-checking bench for lc3_decode.
// Reference model tracks outputs from opcode tables each cycle.
module tb_lc3_decode;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_decode = 1'b1;
  logic [15:0] dout = 16'h1283;
  logic [15:0] npc_in = 16'h0;

  logic [15:0] IR, npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control, valid_out, illegal_op;
  logic [15:0] instr_count;

  logic [15:0] IR2, npc_out2;
  logic [5:0]  E2;
  logic [1:0]  W2;
  logic        M2, V2, I2;
  logic [1:0]  cnt2;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clock = ~clock;

  lc3_decode dut (
    .clock(clock), .reset(reset), .enable_decode(enable_decode),
    .dout(dout), .npc_in(npc_in), .IR(IR), .npc_out(npc_out),
    .E_Control(E_Control), .W_Control(W_Control),
    .Mem_Control(Mem_Control), .valid_out(valid_out),
    .illegal_op(illegal_op), .instr_count(instr_count)
  );

  lc3_decode #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .enable_decode(enable_decode),
    .dout(dout), .npc_in(npc_in), .IR(IR2), .npc_out(npc_out2),
    .E_Control(E2), .W_Control(W2),
    .Mem_Control(M2), .valid_out(V2),
    .illegal_op(I2), .instr_count(cnt2)
  );

  // opcode tables: alu, pcsel1, pcsel2, W, Mem, illegal
  int t_alu [16] = '{0,0,0,0,0,1,0,0,0,2,0,0,0,0,0,0};
  int t_p1  [16] = '{1,0,1,1,0,0,2,2,0,0,1,1,3,0,1,0};
  int t_p2  [16] = '{1,0,1,1,0,0,0,0,0,0,1,1,0,0,1,0};
  int t_w   [16] = '{0,0,2,0,0,0,2,0,0,0,2,0,0,0,1,0};
  int t_mem [16] = '{0,0,0,0,0,0,0,0,0,0,1,1,0,0,0,0};
  int t_ill [16] = '{0,0,0,0,1,0,0,0,1,0,0,0,0,1,0,1};

  logic [15:0] m_ir, m_npc;
  int m_e, m_w, m_mem, m_ill, m_valid, m_cnt, m_cnt2;

  function automatic int ref_e(input logic [15:0] i);
    int op;
    int op2;
    op  = int'(i[15:12]);
    op2 = ((op == 1) || (op == 5)) ? (i[5] ? 0 : 1) : 0;
    return t_alu[op] * 16 + t_p1[op] * 4 + t_p2[op] * 2 + op2;
  endfunction

  // Reference model advanced on every rising edge.
  always @(posedge clock) begin
    if (reset) begin
      m_ir = 0; m_npc = 0; m_e = 0; m_w = 0; m_mem = 0;
      m_ill = 0; m_valid = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      m_valid = enable_decode ? 1 : 0;
      if (enable_decode) begin
        m_ir  = dout;
        m_npc = npc_in;
        m_e   = ref_e(dout);
        m_w   = t_w[dout[15:12]];
        m_mem = t_mem[dout[15:12]];
        m_ill = t_ill[dout[15:12]];
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clock) begin
    if (chk_on) begin
      chk("m_ir", int'(IR), int'(m_ir));
      chk("m_npc", int'(npc_out), int'(m_npc));
      chk("m_e", int'(E_Control), m_e);
      chk("m_w", int'(W_Control), m_w);
      chk("m_mem", int'(Mem_Control), m_mem);
      chk("m_ill", int'(illegal_op), m_ill);
      chk("m_valid", int'(valid_out), m_valid);
      chk("m_cnt", int'(instr_count), m_cnt);
      chk("m_cnt2", int'(cnt2), m_cnt2);
    end
  end

  task automatic step(input logic r, input logic en,
                      input logic [15:0] d, input logic [15:0] n);
    reset = r; enable_decode = en; dout = d; npc_in = n;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // 1: reset with enable high
    repeat (3) step(1'b1, 1'b1, 16'h1283, 16'h0);
    chk_on = 1'b1;
    chk("rst_ir", int'(IR), 0);
    chk("rst_e", int'(E_Control), 0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_cnt", int'(instr_count), 0);
    // 2: ADD register form
    step(1'b0, 1'b1, 16'h1283, 16'h3001);
    chk("add_ir", int'(IR), 'h1283);
    chk("add_npc", int'(npc_out), 'h3001);
    chk("add_e", int'(E_Control), 'b000001);
    chk("add_valid", int'(valid_out), 1);
    chk("add_cnt", int'(instr_count), 1);
    // 3: back-to-back AND imm, LDI, JMP
    step(1'b0, 1'b1, 16'h5020, 16'h3002);
    chk("and_e", int'(E_Control), 'b010000);
    step(1'b0, 1'b1, 16'hA805, 16'h3003);
    chk("ldi_e", int'(E_Control), 'b000110);
    chk("ldi_w", int'(W_Control), 2);
    chk("ldi_mem", int'(Mem_Control), 1);
    step(1'b0, 1'b1, 16'hC1C0, 16'h3004);
    chk("jmp_e", int'(E_Control), 'b001100);
    chk("jmp_mem", int'(Mem_Control), 0);
    chk("jmp_valid", int'(valid_out), 1);
    chk("jmp_cnt", int'(instr_count), 4);
    // 4: hold
    for (int k = 0; k < 5; k++)
      step(1'b0, 1'b0, 16'h1000 + 16'(k), 16'h4000);
    chk("hold_ir", int'(IR), 'hC1C0);
    chk("hold_valid", int'(valid_out), 0);
    chk("hold_cnt", int'(instr_count), 4);
    // 5: illegal then BR
    step(1'b0, 1'b1, 16'hF025, 16'h3005);
    chk("trap_ill", int'(illegal_op), 1);
    chk("trap_e", int'(E_Control), 0);
    chk("trap_ir", int'(IR), 'hF025);
    step(1'b0, 1'b1, 16'h0E02, 16'h3006);
    chk("br_ill", int'(illegal_op), 0);
    chk("br_e", int'(E_Control), 'b000110);
    // sweep all opcodes, both imm-bit values, with gaps
    for (int op = 0; op < 16; op++) begin
      step(1'b0, 1'b1, 16'(op << 12) | 16'h0023, 16'(16'h5000 + op));
      step(1'b0, 1'b1, 16'(op << 12) | 16'h0003, 16'(16'h6000 + op));
      step(1'b0, 1'b0, 16'hFFFF, 16'h0);
    end
    chk("lea_w_last", int'(W_Control), 0);
    // 6: reset wins over enable
    step(1'b1, 1'b1, 16'hE005, 16'h3007);
    chk("rst2_ir", int'(IR), 0);
    chk("rst2_npc", int'(npc_out), 0);
    chk("rst2_valid", int'(valid_out), 0);
    chk("rst2_cnt", int'(instr_count), 0);
    chk("rst2_cnt2", int'(cnt2), 0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 16'hE005, 16'(16'h3100 + k));
      chk("sat_cnt2", int'(cnt2), (k < 3) ? k + 1 : 3);
    end
    chk("lea_w", int'(W_Control), 1);
    chk("lea_e", int'(E_Control), 'b000110);
    step(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
